// File: rtl/fetch_unit.sv
// Instruction fetch stage sitting in front of the shared memory controller.
// Holds the PC, issues one fetch request at a time and hands completed
// instructions to decode through a single valid/stall slot. The memory
// stage always wins the controller, and execute can redirect the PC.

module fetch_unit #(
  parameter int          ADDR_W      = 18,
  parameter int          DATA_W      = 32,
  parameter int          MEM_LATENCY = 2,
  parameter int          PC_STEP     = 2,
  parameter int unsigned RESET_PC    = 0
) (
  input  logic              clock,
  input  logic              reset,
  output logic              if_mc_en,
  output logic [ADDR_W-1:0] if_mc_addr,
  input  logic [DATA_W-1:0] mc_if_data,
  input  logic              mem_mc_en,
  input  logic              ex_if_branch_en,
  input  logic [ADDR_W-1:0] ex_if_branch_addr,
  input  logic              id_if_stall,
  output logic              if_id_valid,
  output logic [DATA_W-1:0] if_id_instr,
  output logic [ADDR_W-1:0] if_id_pc
);

  // Beat counter only has to reach MEM_LATENCY-1; keep at least one bit so
  // a single-cycle controller still has a legal counter.
  localparam int                CNT_W    = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MEM_LATENCY - 1);
  localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(PC_STEP);
  localparam logic [ADDR_W-1:0] PC_INIT  = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] ALIGN    = ~(ADDR_W'(1));

  // FETCH counts beats of the current request; HOLD parks a completed word
  // at the controller output while decode still owns the slot.
  typedef enum logic {
    FETCH,
    HOLD
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] pc;

  logic              consume;
  logic              slot_free;
  logic              at_last;
  logic              fetch_done;
  logic              load;
  logic [ADDR_W-1:0] pc_next;

  // Slot handshake, fetch completion and next-PC selection for this edge.
  always_comb begin
    consume    = if_id_valid && !id_if_stall;
    slot_free  = !if_id_valid || consume;
    at_last    = (state == HOLD) || (cnt == CNT_LAST);
    fetch_done = if_mc_en && !mem_mc_en && at_last;
    load       = !ex_if_branch_en && fetch_done && slot_free;
    pc_next    = pc;
    if (ex_if_branch_en) begin
      pc_next = ex_if_branch_addr & ALIGN;
    end else if (load) begin
      pc_next = pc + STEP;
    end
  end

  // Fetch sequencer: request issue, beat counting, capture into the decode
  // slot, yielding to the memory stage and branch redirects.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= FETCH;
      cnt         <= '0;
      pc          <= PC_INIT;
      if_mc_en    <= 1'b0;
      if_mc_addr  <= '0;
      if_id_valid <= 1'b0;
      if_id_instr <= '0;
      if_id_pc    <= '0;
    end else begin
      pc         <= pc_next;
      if_mc_addr <= pc_next;
      if (ex_if_branch_en) begin
        state       <= FETCH;
        cnt         <= '0;
        if_mc_en    <= !mem_mc_en;
        if_id_valid <= 1'b0;
      end else if (mem_mc_en) begin
        state    <= FETCH;
        cnt      <= '0;
        if_mc_en <= 1'b0;
        if (consume) begin
          if_id_valid <= 1'b0;
        end
      end else if (!if_mc_en) begin
        state    <= FETCH;
        cnt      <= '0;
        if_mc_en <= 1'b1;
        if (consume) begin
          if_id_valid <= 1'b0;
        end
      end else if (at_last) begin
        if (slot_free) begin
          state       <= FETCH;
          cnt         <= '0;
          if_id_valid <= 1'b1;
          if_id_instr <= mc_if_data;
          if_id_pc    <= pc;
        end else begin
          state <= HOLD;
        end
      end else begin
        cnt <= cnt + CNT_W'(1);
        if (consume) begin
          if_id_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus a randomized
// run against a transaction-level reference model of the fetch stage.

module tb_fetch_unit;

  localparam int AW   = 18;
  localparam int DW   = 32;
  localparam int LAT  = 2;
  localparam int STEP = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          if_mc_en;
  logic [AW-1:0] if_mc_addr;
  logic [DW-1:0] mc_if_data;
  logic          mem_mc_en;
  logic          ex_if_branch_en;
  logic [AW-1:0] ex_if_branch_addr;
  logic          id_if_stall;
  logic          if_id_valid;
  logic [DW-1:0] if_id_instr;
  logic [AW-1:0] if_id_pc;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  fetch_unit #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LATENCY(LAT), .PC_STEP(STEP), .RESET_PC(0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .if_mc_en(if_mc_en),
    .if_mc_addr(if_mc_addr),
    .mc_if_data(mc_if_data),
    .mem_mc_en(mem_mc_en),
    .ex_if_branch_en(ex_if_branch_en),
    .ex_if_branch_addr(ex_if_branch_addr),
    .id_if_stall(id_if_stall),
    .if_id_valid(if_id_valid),
    .if_id_instr(if_id_instr),
    .if_id_pc(if_id_pc)
  );

  // Controller model: the word {14'h0,addr} appears only once the same
  // address has been granted for LAT consecutive cycles; junk otherwise.
  int            granted;
  logic [AW-1:0] last_addr;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      granted   <= 0;
      last_addr <= '0;
    end else if (if_mc_en && !mem_mc_en) begin
      granted   <= (if_mc_addr == last_addr && granted > 0) ? granted + 1 : 1;
      last_addr <= if_mc_addr;
    end else begin
      granted <= 0;
    end
  end

  always_comb begin
    mc_if_data = 32'hBAD0_BAD0;
    if (if_mc_en && !mem_mc_en && (LAT == 1 || (granted >= LAT - 1 && if_mc_addr == last_addr)))
      mc_if_data = {14'h0, if_mc_addr};
  end

  // Reference model: request state, granted beats at the current address,
  // and the one-instruction slot.
  typedef struct packed {
    logic          en;
    logic          valid;
    logic [AW-1:0] pc;
    logic [AW-1:0] ipc;
    logic [DW-1:0] instr;
    logic [7:0]    beats;
  } model_t;

  model_t m;

  function automatic model_t model_next(input model_t s, input logic stall, input logic mem,
                                        input logic br, input logic [AW-1:0] br_addr);
    model_t n;
    logic   consume;
    logic   done;
    n       = s;
    consume = s.valid && !stall;
    done    = 1'b0;
    if (br) begin
      n.pc    = br_addr & 18'h3FFFE;
      n.beats = '0;
      n.valid = 1'b0;
      n.en    = !mem;
    end else if (mem) begin
      n.en    = 1'b0;
      n.beats = '0;
      if (consume) n.valid = 1'b0;
    end else begin
      if (s.en) begin
        if (s.beats < 8'd200) n.beats = s.beats + 8'd1;
        done = (int'(n.beats) >= LAT);
      end
      if (done && (!s.valid || consume)) begin
        n.valid = 1'b1;
        n.ipc   = s.pc;
        n.instr = {14'h0, s.pc};
        n.pc    = s.pc + 18'(STEP);
        n.beats = '0;
      end else if (consume) begin
        n.valid = 1'b0;
      end
      n.en = 1'b1;
    end
    return n;
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) m <= '0;
    else       m <= model_next(m, id_if_stall, mem_mc_en, ex_if_branch_en, ex_if_branch_addr);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    id_if_stall       = 1'b0;
    mem_mc_en         = 1'b0;
    ex_if_branch_en   = 1'b0;
    ex_if_branch_addr = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (if_id_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    vectors++;
    if (if_id_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL %s timeout: valid got %b want 1", tag, if_id_valid);
    end
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    tick();
    #2 reset = 1'b1;
    #1;
    vectors += 3;
    if (if_mc_en !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_en got %b want 0", if_mc_en); end
    if (if_id_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_valid got %b want 0", if_id_valid); end
    if (if_mc_addr !== 18'h0) begin miscompares++; $display("[TB] FAIL reset_addr got %h want 0", if_mc_addr); end
    @(negedge clock);
    reset = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      vectors += 2;
      if (if_mc_en !== m.en) begin miscompares++; $display("[TB] FAIL rst_seq_en[%0d] got %b want %b", i, if_mc_en, m.en); end
      if (if_mc_en && if_mc_addr !== m.pc) begin miscompares++; $display("[TB] FAIL rst_seq_addr[%0d] got %h want %h", i, if_mc_addr, m.pc); end
      if (i == 1 || i == 3 || i == 5) begin
        vectors++;
        if (if_mc_addr !== 18'(i - 1)) begin
          miscompares++;
          $display("[TB] FAIL rst_addr_order[%0d] got %h want %h", i, if_mc_addr, 18'(i - 1));
        end
      end
    end
  endtask

  task automatic test_straight_line();
    logic [AW-1:0] seen[$];
    logic [AW-1:0] want[4];
    want = '{18'h0, 18'h2, 18'h4, 18'h6};
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      tick();
      vectors += 3;
      if (if_id_valid !== m.valid) begin miscompares++; $display("[TB] FAIL line_valid[%0d] got %b want %b", i, if_id_valid, m.valid); end
      if (m.valid && if_id_instr !== m.instr) begin miscompares++; $display("[TB] FAIL line_instr[%0d] got %h want %h", i, if_id_instr, m.instr); end
      if (m.valid && if_id_pc !== m.ipc) begin miscompares++; $display("[TB] FAIL line_pc[%0d] got %h want %h", i, if_id_pc, m.ipc); end
      if (if_id_valid === 1'b1) seen.push_back(if_id_pc);
    end
    vectors++;
    if (seen.size() != 4) begin
      miscompares++;
      $display("[TB] FAIL line_count got %0d want 4", seen.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if (seen[k] !== want[k]) begin miscompares++; $display("[TB] FAIL line_order[%0d] got %h want %h", k, seen[k], want[k]); end
      end
    end
  endtask

  task automatic test_stall_hold();
    do_reset();
    wait_valid("stall_first");
    id_if_stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      vectors += 3;
      if (if_id_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_valid[%0d] got %b want 1", i, if_id_valid); end
      if (if_id_pc !== 18'h0) begin miscompares++; $display("[TB] FAIL stall_pc[%0d] got %h want 0", i, if_id_pc); end
      if (if_id_instr !== 32'h0) begin miscompares++; $display("[TB] FAIL stall_instr[%0d] got %h want 0", i, if_id_instr); end
    end
    vectors += 2;
    if (if_mc_en !== 1'b1) begin miscompares++; $display("[TB] FAIL hold_en got %b want 1", if_mc_en); end
    if (if_mc_addr !== 18'h2) begin miscompares++; $display("[TB] FAIL hold_addr got %h want 2", if_mc_addr); end
    id_if_stall = 1'b0;
    tick();
    vectors += 2;
    if (if_id_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_valid got %b want 1", if_id_valid); end
    if (if_id_pc !== 18'h2 || if_id_instr !== 32'h2) begin
      miscompares++;
      $display("[TB] FAIL b2b_slot got pc=%h instr=%h want pc=2 instr=2", if_id_pc, if_id_instr);
    end
    tick();
    vectors++;
    if (if_id_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_drain got %b want 0", if_id_valid); end
  endtask

  task automatic test_branch_flush();
    do_reset();
    wait_valid("branch_first");
    id_if_stall = 1'b1;
    tick(); tick(); tick();
    ex_if_branch_en   = 1'b1;
    ex_if_branch_addr = 18'h101;
    tick();
    ex_if_branch_en = 1'b0;
    vectors += 3;
    if (if_id_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL flush_valid got %b want 0", if_id_valid); end
    if (if_mc_en !== 1'b1) begin miscompares++; $display("[TB] FAIL flush_en got %b want 1", if_mc_en); end
    if (if_mc_addr !== 18'h100) begin miscompares++; $display("[TB] FAIL flush_addr got %h want 100", if_mc_addr); end
    id_if_stall = 1'b0;
    wait_valid("branch_target");
    vectors++;
    if (if_id_pc !== 18'h100 || if_id_instr !== 32'h100) begin
      miscompares++;
      $display("[TB] FAIL branch_slot got pc=%h instr=%h want pc=100 instr=100", if_id_pc, if_id_instr);
    end
  endtask

  task automatic test_mem_conflict();
    do_reset();
    wait_valid("conflict_first");
    tick();
    mem_mc_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors += 2;
      if (if_mc_en !== 1'b0) begin miscompares++; $display("[TB] FAIL conflict_en[%0d] got %b want 0", i, if_mc_en); end
      if (if_id_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL conflict_capture[%0d] got %b want 0", i, if_id_valid); end
    end
    mem_mc_en = 1'b0;
    tick();
    vectors += 2;
    if (if_mc_en !== 1'b1 || if_mc_addr !== 18'h2) begin
      miscompares++;
      $display("[TB] FAIL restart_req got en=%b addr=%h want en=1 addr=2", if_mc_en, if_mc_addr);
    end
    if (if_id_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL restart_early1 got %b want 0", if_id_valid); end
    tick();
    vectors++;
    if (if_id_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL restart_early2 got %b want 0", if_id_valid); end
    tick();
    vectors++;
    if (if_id_valid !== 1'b1 || if_id_pc !== 18'h2 || if_id_instr !== 32'h2) begin
      miscompares++;
      $display("[TB] FAIL restart_done got v=%b pc=%h instr=%h want v=1 pc=2 instr=2", if_id_valid, if_id_pc, if_id_instr);
    end
  endtask

  task automatic test_pc_wrap();
    do_reset();
    ex_if_branch_en   = 1'b1;
    ex_if_branch_addr = 18'h3FFFE;
    tick();
    ex_if_branch_en = 1'b0;
    wait_valid("wrap");
    vectors += 2;
    if (if_id_pc !== 18'h3FFFE || if_id_instr !== 32'h3FFFE) begin
      miscompares++;
      $display("[TB] FAIL wrap_slot got pc=%h instr=%h want pc=3fffe instr=3fffe", if_id_pc, if_id_instr);
    end
    if (if_mc_en !== 1'b1 || if_mc_addr !== 18'h0) begin
      miscompares++;
      $display("[TB] FAIL wrap_next got en=%b addr=%h want en=1 addr=0", if_mc_en, if_mc_addr);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      id_if_stall     = ($urandom_range(0, 99) < 35);
      mem_mc_en       = ($urandom_range(0, 99) < 15);
      ex_if_branch_en = ($urandom_range(0, 99) < 4);
      if ($urandom_range(0, 3) == 0) ex_if_branch_addr = 18'h3FFF0 + 18'($urandom_range(0, 15));
      else                           ex_if_branch_addr = 18'($urandom);
      tick();
      vectors += 5;
      if (if_id_valid !== m.valid) begin miscompares++; $display("[TB] FAIL rnd_valid[%0d] got %b want %b", i, if_id_valid, m.valid); end
      if (m.valid && if_id_instr !== m.instr) begin miscompares++; $display("[TB] FAIL rnd_instr[%0d] got %h want %h", i, if_id_instr, m.instr); end
      if (m.valid && if_id_pc !== m.ipc) begin miscompares++; $display("[TB] FAIL rnd_pc[%0d] got %h want %h", i, if_id_pc, m.ipc); end
      if (if_mc_en !== m.en) begin miscompares++; $display("[TB] FAIL rnd_en[%0d] got %b want %b", i, if_mc_en, m.en); end
      if (m.en && if_mc_addr !== m.pc) begin miscompares++; $display("[TB] FAIL rnd_addr[%0d] got %h want %h", i, if_mc_addr, m.pc); end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    test_reset();
    test_straight_line();
    test_stall_hold();
    test_branch_flush();
    test_mem_conflict();
    test_pc_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

endmodule
